// File: rtl/instr_fetch_unit.sv
// Fetch stage between the program counter and decode: issues one instruction-memory
// request at a time, advances or redirects the PC, and queues fetched words for decode.
module instr_fetch_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] current_address,
    output logic [ADDR_WIDTH-1:0] next_address,
    output logic                  pc_write,
    output logic                  imem_req_valid,
    output logic [ADDR_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_req_ready,
    input  logic                  imem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] imem_rsp_data,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_addr,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_instr,
    output logic [ADDR_WIDTH-1:0] out_pc,
    input  logic                  out_ready
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0]      DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] INCR_C  = ADDR_WIDTH'(3'd4);

    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_REQ   = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [ADDR_WIDTH-1:0]   req_pc_r;
    logic [DATA_WIDTH-1:0]   instr_mem_r [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0]   pc_mem_r    [FIFO_DEPTH];
    logic [PTR_W-1:0]        rd_ptr_r;
    logic [PTR_W-1:0]        wr_ptr_r;
    logic [CNT_W-1:0]        count_r;

    logic                    req_valid_s;
    logic                    push_s;
    logic                    pop_s;
    logic                    flush_s;
    logic                    latch_s;
    logic                    fifo_full_s;
    logic                    fifo_empty_s;
    logic [ADDR_WIDTH-1:0]   redir_tgt_s;
    logic                    unused_redir_lsb_s;

    assign fifo_full_s        = (count_r == DEPTH_C);
    assign fifo_empty_s       = (count_r == {CNT_W{1'b0}});
    assign pop_s              = !fifo_empty_s && out_ready;
    assign redir_tgt_s        = {redirect_addr[ADDR_WIDTH-1:2], 2'b00};
    assign unused_redir_lsb_s = ^redirect_addr[1:0];

    assign imem_req_valid = req_valid_s;
    assign imem_req_addr  = current_address;
    assign out_valid      = !fifo_empty_s;
    assign out_instr      = instr_mem_r[rd_ptr_r];
    assign out_pc         = pc_mem_r[rd_ptr_r];

    // Next-state, PC update and request/FIFO control; a redirect overrides everything after START
    always_comb begin
        state_nxt_s  = state_r;
        next_address = current_address;
        pc_write     = 1'b0;
        req_valid_s  = 1'b0;
        push_s       = 1'b0;
        flush_s      = 1'b0;
        latch_s      = 1'b0;
        case (state_r)
            ST_START: begin
                state_nxt_s = ST_REQ;
            end
            ST_REQ: begin
                if (redirect_valid) begin
                    pc_write     = 1'b1;
                    next_address = redir_tgt_s;
                    flush_s      = 1'b1;
                end else begin
                    // nothing is outstanding in REQ, so only buffer space gates the request
                    req_valid_s = !fifo_full_s;
                    if (req_valid_s && imem_req_ready) begin
                        pc_write     = 1'b1;
                        next_address = current_address + INCR_C;
                        latch_s      = 1'b1;
                        state_nxt_s  = ST_WAIT;
                    end else begin
                        state_nxt_s = ST_REQ;
                    end
                end
            end
            ST_WAIT: begin
                if (redirect_valid) begin
                    pc_write     = 1'b1;
                    next_address = redir_tgt_s;
                    flush_s      = 1'b1;
                    state_nxt_s  = imem_rsp_valid ? ST_REQ : ST_DRAIN;
                end else if (imem_rsp_valid) begin
                    push_s      = 1'b1;
                    state_nxt_s = ST_REQ;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_DRAIN: begin
                // a response arriving alongside a redirect is the stale one being drained
                if (redirect_valid) begin
                    pc_write     = 1'b1;
                    next_address = redir_tgt_s;
                    flush_s      = 1'b1;
                    state_nxt_s  = imem_rsp_valid ? ST_REQ : ST_DRAIN;
                end else if (imem_rsp_valid) begin
                    state_nxt_s = ST_REQ;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            default: begin
                state_nxt_s = ST_START;
            end
        endcase
    end

    // State register and the address of the request in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r  <= ST_START;
            req_pc_r <= {ADDR_WIDTH{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            if (latch_s) begin
                req_pc_r <= current_address;
            end
        end
    end

    // Instruction buffer: push on response, pop on decode handshake, flush on redirect
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                instr_mem_r[i] <= {DATA_WIDTH{1'b0}};
                pc_mem_r[i]    <= {ADDR_WIDTH{1'b0}};
            end
        end else if (flush_s) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                instr_mem_r[wr_ptr_r] <= imem_rsp_data;
                pc_mem_r[wr_ptr_r]    <= req_pc_r;
                wr_ptr_r              <= wr_ptr_r + PTR_W'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1'b1);
                2'b01:   count_r <= count_r - CNT_W'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    instr_fetch_unit_chk u_chk (
        .clk   (clk),
        .reset (reset),
        .push  (push_s),
        .full  (fifo_full_s)
    );

endmodule

// Invariant checker for the fetch buffer: request gating must prevent a push into a full FIFO.
module instr_fetch_unit_chk (
    input logic clk,
    input logic reset,
    input logic push,
    input logic full
);

    a_no_overflow: assert property (@(posedge clk) disable iff (!reset) !(push && full));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed vector table, wrap/async-reset
// sequence, and randomized traffic against a transaction-level reference model.
module tb_instr_fetch_unit;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] current_address;
    logic [AW-1:0] next_address;
    logic          pc_write;
    logic          imem_req_valid;
    logic [AW-1:0] imem_req_addr;
    logic          imem_req_ready;
    logic          imem_rsp_valid;
    logic [DW-1:0] imem_rsp_data;
    logic          redirect_valid;
    logic [AW-1:0] redirect_addr;
    logic          out_valid;
    logic [DW-1:0] out_instr;
    logic [AW-1:0] out_pc;
    logic          out_ready;

    always #5 clk = ~clk;

    instr_fetch_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk             (clk),
        .reset           (reset),
        .current_address (current_address),
        .next_address    (next_address),
        .pc_write        (pc_write),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_rsp_valid  (imem_rsp_valid),
        .imem_rsp_data   (imem_rsp_data),
        .redirect_valid  (redirect_valid),
        .redirect_addr   (redirect_addr),
        .out_valid       (out_valid),
        .out_instr       (out_instr),
        .out_pc          (out_pc),
        .out_ready       (out_ready)
    );

    typedef struct {
        logic [31:0] cur;
        logic        rdy;
        logic        rsp;
        logic [31:0] data;
        logic        redir;
        logic [31:0] raddr;
        logic        ordy;
        logic        erv;
        logic        epw;
        logic [31:0] ena;
        logic        eov;
        logic [31:0] eopc;
        logic [31:0] eoin;
    } vec_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic [31:0] cur, input logic rdy, input logic rsp,
                                input logic [31:0] data, input logic redir,
                                input logic [31:0] raddr, input logic ordy,
                                input logic erv, input logic epw, input logic [31:0] ena,
                                input logic eov, input logic [31:0] eopc,
                                input logic [31:0] eoin);
        vec_t v;
        v.cur = cur; v.rdy = rdy; v.rsp = rsp; v.data = data; v.redir = redir;
        v.raddr = raddr; v.ordy = ordy; v.erv = erv; v.epw = epw; v.ena = ena;
        v.eov = eov; v.eopc = eopc; v.eoin = eoin;
        return v;
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic idle_inputs();
        current_address = 32'h0;
        imem_req_ready  = 1'b1;
        imem_rsp_valid  = 1'b0;
        imem_rsp_data   = 32'h0;
        redirect_valid  = 1'b0;
        redirect_addr   = 32'h0;
        out_ready       = 1'b1;
    endtask

    // Holds reset, checks the cleared outputs, releases just after a rising edge (START cycle follows)
    task automatic do_reset();
        reset = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("reset.out_valid", {31'h0, out_valid}, 32'h0);
        chk("reset.req_valid", {31'h0, imem_req_valid}, 32'h0);
        chk("reset.pc_write", {31'h0, pc_write}, 32'h0);
        @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic apply_vec(input vec_t v, input int idx);
        @(negedge clk);
        current_address = v.cur;
        imem_req_ready  = v.rdy;
        imem_rsp_valid  = v.rsp;
        imem_rsp_data   = v.data;
        redirect_valid  = v.redir;
        redirect_addr   = v.raddr;
        out_ready       = v.ordy;
        #1;
        chk($sformatf("v%0d.req_valid", idx), {31'h0, imem_req_valid}, {31'h0, v.erv});
        chk($sformatf("v%0d.req_addr", idx), imem_req_addr, v.cur);
        chk($sformatf("v%0d.pc_write", idx), {31'h0, pc_write}, {31'h0, v.epw});
        chk($sformatf("v%0d.next_address", idx), next_address, v.ena);
        chk($sformatf("v%0d.out_valid", idx), {31'h0, out_valid}, {31'h0, v.eov});
        if (v.eov) begin
            chk($sformatf("v%0d.out_pc", idx), out_pc, v.eopc);
            chk($sformatf("v%0d.out_instr", idx), out_instr, v.eoin);
        end
    endtask

    vec_t tbl[28];
    vec_t wseq[4];
    ent_t q[$];

    initial begin
        logic [31:0] pc_m;
        logic [31:0] maddr;
        logic        pending;
        logic        stale;
        logic        exp_rv;
        logic        exp_pw;
        logic [31:0] exp_na;
        int          wcnt;
        int          lat;

        // free-run, 3-cycle stall, backpressure, redirect in WAIT, redirect with
        // pending request, redirect coincident with response
        tbl[0]  = mk(32'h000, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h000, 1'b0, 32'h0, 32'h0);
        tbl[1]  = mk(32'h000, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h004, 1'b0, 32'h0, 32'h0);
        tbl[2]  = mk(32'h004, 1'b1, 1'b1, 32'hC0DE_0000, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h004, 1'b0, 32'h0, 32'h0);
        tbl[3]  = mk(32'h004, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h008, 1'b1, 32'h000, 32'hC0DE_0000);
        tbl[4]  = mk(32'h008, 1'b1, 1'b1, 32'hC0DE_0001, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h008, 1'b0, 32'h0, 32'h0);
        tbl[5]  = mk(32'h008, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h00C, 1'b1, 32'h004, 32'hC0DE_0001);
        tbl[6]  = mk(32'h00C, 1'b1, 1'b1, 32'hC0DE_0002, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h00C, 1'b0, 32'h0, 32'h0);
        tbl[7]  = mk(32'h00C, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h00C, 1'b1, 32'h008, 32'hC0DE_0002);
        tbl[8]  = mk(32'h00C, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h00C, 1'b0, 32'h0, 32'h0);
        tbl[9]  = mk(32'h00C, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h00C, 1'b0, 32'h0, 32'h0);
        tbl[10] = mk(32'h00C, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h010, 1'b0, 32'h0, 32'h0);
        tbl[11] = mk(32'h010, 1'b1, 1'b1, 32'hC0DE_0003, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h010, 1'b0, 32'h0, 32'h0);
        tbl[12] = mk(32'h010, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h014, 1'b1, 32'h00C, 32'hC0DE_0003);
        tbl[13] = mk(32'h014, 1'b1, 1'b1, 32'hC0DE_0004, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h014, 1'b1, 32'h00C, 32'hC0DE_0003);
        tbl[14] = mk(32'h014, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h014, 1'b1, 32'h00C, 32'hC0DE_0003);
        tbl[15] = mk(32'h014, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h014, 1'b1, 32'h00C, 32'hC0DE_0003);
        tbl[16] = mk(32'h014, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h014, 1'b1, 32'h00C, 32'hC0DE_0003);
        tbl[17] = mk(32'h014, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h018, 1'b1, 32'h010, 32'hC0DE_0004);
        tbl[18] = mk(32'h018, 1'b1, 1'b0, 32'h0, 1'b1, 32'h103, 1'b1, 1'b0, 1'b1, 32'h100, 1'b1, 32'h010, 32'hC0DE_0004);
        tbl[19] = mk(32'h100, 1'b1, 1'b1, 32'hBAD0_0014, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h100, 1'b0, 32'h0, 32'h0);
        tbl[20] = mk(32'h100, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h104, 1'b0, 32'h0, 32'h0);
        tbl[21] = mk(32'h104, 1'b1, 1'b1, 32'hC0DE_0100, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h104, 1'b0, 32'h0, 32'h0);
        tbl[22] = mk(32'h104, 1'b1, 1'b0, 32'h0, 1'b1, 32'h200, 1'b1, 1'b0, 1'b1, 32'h200, 1'b1, 32'h100, 32'hC0DE_0100);
        tbl[23] = mk(32'h200, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h204, 1'b0, 32'h0, 32'h0);
        tbl[24] = mk(32'h204, 1'b1, 1'b1, 32'hBAD0_0200, 1'b1, 32'h300, 1'b1, 1'b0, 1'b1, 32'h300, 1'b0, 32'h0, 32'h0);
        tbl[25] = mk(32'h300, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h304, 1'b0, 32'h0, 32'h0);
        tbl[26] = mk(32'h304, 1'b1, 1'b1, 32'hC0DE_0300, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h304, 1'b0, 32'h0, 32'h0);
        tbl[27] = mk(32'h304, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h304, 1'b1, 32'h300, 32'hC0DE_0300);

        wseq[0] = mk(32'hFFFF_FFFC, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFC, 1'b0, 32'h0, 32'h0);
        wseq[1] = mk(32'hFFFF_FFFC, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0000_0000, 1'b0, 32'h0, 32'h0);
        wseq[2] = mk(32'h0000_0000, 1'b1, 1'b1, 32'hFACE_0001, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 32'h0, 32'h0);
        wseq[3] = mk(32'h0000_0000, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0000_0004, 1'b1, 32'hFFFF_FFFC, 32'hFACE_0001);

        do_reset();
        for (int i = 0; i < 28; i++) apply_vec(tbl[i], i);

        // PC wrap, then asynchronous reset while a request is outstanding
        do_reset();
        for (int i = 0; i < 4; i++) apply_vec(wseq[i], 100 + i);
        @(negedge clk);
        current_address = 32'h4;
        imem_rsp_valid  = 1'b0;
        #1;
        chk("wait.out_valid_before_reset", {31'h0, out_valid}, 32'h1);
        reset = 1'b0;
        #1;
        chk("async_reset.out_valid", {31'h0, out_valid}, 32'h0);
        chk("async_reset.req_valid", {31'h0, imem_req_valid}, 32'h0);
        chk("async_reset.pc_write", {31'h0, pc_write}, 32'h0);

        // Randomized traffic against a transaction-level model
        do_reset();
        pc_m    = 32'h0;
        maddr   = 32'h0;
        pending = 1'b0;
        stale   = 1'b0;
        wcnt    = 0;
        lat     = 1;
        q.delete();
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            current_address = pc_m;
            imem_req_ready  = ($urandom_range(0, 3) != 0);
            out_ready       = ($urandom_range(0, 2) != 0);
            redirect_valid  = (n > 0) && ($urandom_range(0, 19) == 0);
            redirect_addr   = $urandom;
            imem_rsp_valid  = pending && (wcnt >= lat);
            imem_rsp_data   = mem_word(maddr);
            #1;
            exp_rv = (n > 0) && !pending && !redirect_valid && (q.size() < DEPTH);
            exp_pw = 1'b0;
            exp_na = pc_m;
            if (redirect_valid) begin
                exp_pw = 1'b1;
                exp_na = redirect_addr & 32'hFFFF_FFFC;
            end else if (exp_rv && imem_req_ready) begin
                exp_pw = 1'b1;
                exp_na = pc_m + 32'd4;
            end
            chk("rnd.req_valid", {31'h0, imem_req_valid}, {31'h0, exp_rv});
            chk("rnd.req_addr", imem_req_addr, pc_m);
            chk("rnd.pc_write", {31'h0, pc_write}, {31'h0, exp_pw});
            chk("rnd.next_address", next_address, exp_na);
            chk("rnd.out_valid", {31'h0, out_valid}, {31'h0, (q.size() != 0)});
            if (q.size() != 0) begin
                chk("rnd.out_pc", out_pc, q[0].pc);
                chk("rnd.out_instr", out_instr, q[0].ins);
            end
            if ((q.size() != 0) && out_ready) void'(q.pop_front());
            if (imem_rsp_valid) begin
                pending = 1'b0;
                if (!stale && !redirect_valid) q.push_back('{maddr, mem_word(maddr)});
            end else if (pending) begin
                wcnt++;
                if (redirect_valid) stale = 1'b1;
            end
            if (redirect_valid) q.delete();
            if (exp_rv && imem_req_ready) begin
                pending = 1'b1;
                stale   = 1'b0;
                wcnt    = 1;
                lat     = $urandom_range(1, 3);
                maddr   = pc_m;
            end
            if (exp_pw) pc_m = exp_na;
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage directly downstream of the ProgramCounter register.
- Reads current_address from the PC and drives the instruction-memory request.
- Returns next_address and a load enable to the PC: PC+4, or a redirect target.
- Buffers fetched instructions in a small FIFO toward decode, using a valid/ready handshake.

Parameters:
ADDR_WIDTH, 32, width of PC and memory address
DATA_WIDTH, 32, instruction width
FIFO_DEPTH, 2, instruction buffer entries; power of two, >=2

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low (0 = in reset); clears all state immediately
current_address  input  ADDR_WIDTH  PC register output
next_address  output  ADDR_WIDTH  to PC input_address
pc_write  output  1  PC load enable
imem_req_valid  output  1  fetch request valid
imem_req_addr  output  ADDR_WIDTH  fetch address
imem_req_ready  input  1  memory accepts request
imem_rsp_valid  input  1  read data valid (one per accepted request, in order, latency >=1 cycle)
imem_rsp_data  input  DATA_WIDTH  instruction word
redirect_valid  input  1  branch/jump redirect pulse
redirect_addr  input  ADDR_WIDTH  redirect target
out_valid  output  1  instruction available to decode
out_instr  output  DATA_WIDTH  instruction at FIFO head
out_pc  output  ADDR_WIDTH  address of out_instr
out_ready  input  1  decode accepts

Behaviour:
- States: START, REQ, WAIT, DRAIN. At most one outstanding memory request.
- Reset (reset=0):
  - state=START; FIFO empty; outstanding=0.
  - out_valid=0, imem_req_valid=0, pc_write=0; all registered outputs 0.
- START: one cycle after reset release, then REQ. No request is issued in START.
- REQ:
  - imem_req_valid=1 iff fifo_count+outstanding < FIFO_DEPTH and redirect_valid=0.
  - imem_req_addr = current_address.
  - On valid&&ready:
    - pc_write=1, next_address = current_address+4, modulo 2^ADDR_WIDTH (0xFFFFFFFC -> 0x0).
    - Latch req_pc = current_address; go to WAIT.
  - Held request keeps a stable address until accepted. A redirect may withdraw it.
- WAIT:
  - On imem_rsp_valid, push {req_pc, imem_rsp_data} into the FIFO and return to REQ.
  - The next request may issue the cycle after the response (throughput 1 instr / 2 cycles minimum).
- Default outputs: pc_write=0, next_address=current_address.
- Redirect (highest priority, any state except START):
  - Same cycle: pc_write=1, next_address = redirect_addr with bits[1:0] forced to 0.
  - imem_req_valid forced 0.
  - FIFO flushed; out_valid=0 from the next cycle.
  - A same-cycle out_ready pop is still a legal transfer of the current head.
  - State after redirect:
    - WAIT, no response this cycle -> DRAIN.
    - WAIT with imem_rsp_valid this cycle -> response discarded, go to REQ.
    - REQ -> REQ.
    - DRAIN -> DRAIN.
- DRAIN: discard the next imem_rsp_valid without pushing, then go to REQ.
- FIFO:
  - out_valid = !empty; out_instr/out_pc show the head combinationally.
  - Pop on out_valid&&out_ready.
  - Simultaneous push and pop keeps the count constant.
  - Overflow is impossible by request gating; push when full is a design error (assertion).
- Pointers wrap modulo FIFO_DEPTH; count range 0..FIFO_DEPTH.
- Reset asserted mid-request: all state cleared. Any late memory response after reset release is outside the contract; the memory is reset too.

Test Plan:
- Reset then free-run (PC reset 0x0, imem_req_ready=1, rsp latency 1, out_ready=1):
  - Requests go to 0x0, 0x4, 0x8.
  - Decode sees (0x0,I0), (0x4,I1), (0x8,I2) in order.
  - pc_write pulses once per accepted request.
- Backpressure, out_ready=0:
  - Exactly FIFO_DEPTH=2 requests issue (0x0, 0x4), then imem_req_valid stays 0 and the PC holds at 0x8.
  - Raising out_ready resumes at 0x8.
- Memory stall, imem_req_ready=0 for 3 cycles:
  - imem_req_valid=1 and imem_req_addr=0x0 stable all 3 cycles, with pc_write=0.
  - Accept on cycle 4 -> next_address=0x4.
- Redirect during WAIT (request 0x8 outstanding, redirect to 0x103):
  - next_address=0x100 and the FIFO is flushed.
  - The 0x8 response is dropped.
  - The next request is 0x100; decode next sees out_pc=0x100.
- Redirect coincident with response, and with a pending request:
  - Both cases: response or request discarded, no pc+4 update.
  - Only the redirect target is fetched next.
- Wrap and async reset:
  - PC=0xFFFFFFFC accepted -> next_address=0x0.
  - Asserting reset mid-WAIT immediately drops out_valid and imem_req_valid to 0.
